fx3_link_ctrl: RTL and testbench

- Sequences the FX3 connection/status path.
- Qualifies FX3 connect and disconnect, tracks the GPI status bit while linked, and reports both to the shared status-register bus over a req/ack write handshake.
- Sits between the FX3 GPIO pins and the register-file write port.
- Arbitrates between link-event writes and GPI-change writes so that only one write is outstanding at a time.

---
 rtl/fx3_link_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fx3_link_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_link_ctrl.sv
// FX3 link controller: qualifies connect/disconnect and GPI changes, reports them via req/ack writes.
// Define FX3_SYNC_EN to pass fx3_ready and gpi_status through 2-flop synchronizers first.
module fx3_link_ctrl #(
  parameter int unsigned CONNECT_CYCLES    = 4000,
  parameter int unsigned DISCONNECT_CYCLES = 40,
  parameter int unsigned ACK_TIMEOUT       = 64,
  parameter logic [7:0]  LINK_ADDR         = 8'h10,
  parameter logic [7:0]  GPI_ADDR          = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fx3_ready,
  input  logic       gpi_status,
  input  logic       reg_wr_ack,
  output logic       reg_wr_req,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       usb_connected,
  output logic       ack_error
);

  localparam int unsigned CNT_MAX = (CONNECT_CYCLES > DISCONNECT_CYCLES) ? CONNECT_CYCLES
                                                                         : DISCONNECT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned WCNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    DISC,
    QUAL_CONN,
    CONN,
    QUAL_DISC
  } link_state_e;

  typedef enum logic {
    W_IDLE,
    W_REQ
  } wr_state_e;

  logic r;
  logic g;

`ifdef FX3_SYNC_EN
  logic [1:0] ready_sync_q;
  logic [1:0] gpi_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_sync_q <= '0;
      gpi_sync_q   <= '0;
    end else begin
      ready_sync_q <= {ready_sync_q[0], fx3_ready};
      gpi_sync_q   <= {gpi_sync_q[0], gpi_status};
    end
  end

  assign r = ready_sync_q[1];
  assign g = gpi_sync_q[1];
`else
  assign r = fx3_ready;
  assign g = gpi_status;
`endif

  link_state_e       link_state_q, link_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              usb_connected_q;
  logic              linked;
  logic              link_event;

  wr_state_e         wr_state_q, wr_state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              req_q, req_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [3:0]        seq_q, seq_d;
  logic              ack_error_q, ack_error_d;
  logic              gpi_last_q, gpi_last_d;
  logic              link_pending_q, link_pending_d;
  logic              gpi_pending_q, gpi_pending_d;
  logic              issue;
  logic              issue_link;

  assign linked = (link_state_q == CONN) || (link_state_q == QUAL_DISC);

  always_comb begin : link_next
    link_state_d = link_state_q;
    cnt_d        = cnt_q;
    link_event   = 1'b0;
    case (link_state_q)
      DISC: begin
        if (r) begin
          link_state_d = QUAL_CONN;
          cnt_d        = '0;
        end
      end
      QUAL_CONN: begin
        if (!r) begin
          link_state_d = DISC;
        end else if (cnt_q == CNT_W'(CONNECT_CYCLES - 1)) begin
          link_state_d = CONN;
          link_event   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONN: begin
        if (!r) begin
          link_state_d = QUAL_DISC;
          cnt_d        = '0;
        end
      end
      QUAL_DISC: begin
        if (r) begin
          link_state_d = CONN;
        end else if (cnt_q == CNT_W'(DISCONNECT_CYCLES - 1)) begin
          link_state_d = DISC;
          link_event   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: link_state_d = DISC;
    endcase
  end

  always_comb begin : write_next
    wr_state_d  = wr_state_q;
    wcnt_d      = wcnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    data_d      = data_q;
    seq_d       = seq_q;
    ack_error_d = ack_error_q;
    gpi_last_d  = gpi_last_q;
    issue       = 1'b0;
    issue_link  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (link_pending_q || gpi_pending_q) begin
          issue       = 1'b1;
          issue_link  = link_pending_q;
          wr_state_d  = W_REQ;
          wcnt_d      = '0;
          req_d       = 1'b1;
          addr_d      = link_pending_q ? LINK_ADDR : GPI_ADDR;
          data_d      = {seq_q, link_pending_q, ack_error_q, g, linked};
          seq_d       = seq_q + 4'd1;
          gpi_last_d  = g;
        end
      end
      W_REQ: begin
        // Ack is checked first so an ack on the final timeout cycle still succeeds.
        if (reg_wr_ack) begin
          wr_state_d = W_IDLE;
          req_d      = 1'b0;
        end else if (wcnt_q == WCNT_W'(ACK_TIMEOUT - 1)) begin
          wr_state_d  = W_IDLE;
          req_d       = 1'b0;
          ack_error_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    // A new event of the served type survives the clear; the issue cycle itself
    // refreshes gpi_last, so it does not count as a GPI change.
    link_pending_d = (link_pending_q & ~issue_link) | link_event;
    gpi_pending_d  = (gpi_pending_q & ~issue) | (linked & (g != gpi_last_q) & ~issue);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      link_state_q    <= DISC;
      cnt_q           <= '0;
      usb_connected_q <= 1'b0;
      wr_state_q      <= W_IDLE;
      wcnt_q          <= '0;
      req_q           <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      seq_q           <= '0;
      ack_error_q     <= 1'b0;
      gpi_last_q      <= 1'b0;
      link_pending_q  <= 1'b0;
      gpi_pending_q   <= 1'b0;
    end else begin
      link_state_q    <= link_state_d;
      cnt_q           <= cnt_d;
      usb_connected_q <= linked;
      wr_state_q      <= wr_state_d;
      wcnt_q          <= wcnt_d;
      req_q           <= req_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      seq_q           <= seq_d;
      ack_error_q     <= ack_error_d;
      gpi_last_q      <= gpi_last_d;
      link_pending_q  <= link_pending_d;
      gpi_pending_q   <= gpi_pending_d;
    end
  end

  assign reg_wr_req    = req_q;
  assign reg_wr_addr   = addr_q;
  assign reg_wr_data   = data_q;
  assign usb_connected = usb_connected_q;
  assign ack_error     = ack_error_q;

endmodule

// File: tb/tb_fx3_link_ctrl.sv
// Bench for fx3_link_ctrl: run-length/event reference model, per-cycle compare, directed and random stimulus.
module tb_fx3_link_ctrl;

  localparam int unsigned C_CYC = 8;
  localparam int unsigned D_CYC = 4;
  localparam int unsigned T_ACK = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fx3_ready = 1'b0;
  logic       gpi_status = 1'b0;
  logic       reg_wr_ack = 1'b0;
  logic       reg_wr_req;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       usb_connected;
  logic       ack_error;

  fx3_link_ctrl #(
    .CONNECT_CYCLES   (C_CYC),
    .DISCONNECT_CYCLES(D_CYC),
    .ACK_TIMEOUT      (T_ACK),
    .LINK_ADDR        (8'h10),
    .GPI_ADDR         (8'h11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fx3_ready    (fx3_ready),
    .gpi_status   (gpi_status),
    .reg_wr_ack   (reg_wr_ack),
    .reg_wr_req   (reg_wr_req),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .usb_connected(usb_connected),
    .ack_error    (ack_error)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 1'b0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: link qualification as run lengths of the ready level,
  // handshake timeout as elapsed cycles since issue.
  int unsigned hi_run, lo_run, cyc, req_cycle;
  bit          conn, lp, gp, glast, busy, err;
  bit [3:0]    seq;
  bit [7:0]    m_addr, m_data;
  bit          m_usb, m_req;

  task automatic model_step(input bit rst, input bit rv, input bit gv, input bit ack);
    bit conn_b, glast_b, iss, ev;
    cyc++;
    if (rst) begin
      hi_run = 0; lo_run = 0; conn = 0; lp = 0; gp = 0; glast = 0;
      busy = 0; err = 0; seq = 0; m_addr = 0; m_data = 0; m_usb = 0; m_req = 0;
      return;
    end
    conn_b  = conn;
    glast_b = glast;
    hi_run  = rv ? hi_run + 1 : 0;
    lo_run  = rv ? 0 : lo_run + 1;
    ev = 0;
    if (!conn_b && hi_run == C_CYC + 1) begin conn = 1; ev = 1; end
    if (conn_b && lo_run == D_CYC + 1) begin conn = 0; ev = 1; end

    iss = !busy && (lp || gp);
    if (busy) begin
      if (ack) busy = 0;
      else if (cyc - req_cycle == T_ACK) begin busy = 0; err = 1; end
    end else if (iss) begin
      m_addr = lp ? 8'h10 : 8'h11;
      m_data = {seq, lp, err, gv, conn_b};
      seq    = seq + 1;
      busy   = 1;
      req_cycle = cyc;
      if (lp) begin lp = 0; gp = 0; end else gp = 0;
      glast = gv;
    end
    if (ev) lp = 1;
    if (conn_b && gv != glast_b && !iss) gp = 1;
    m_usb = conn_b;
    m_req = busy;
  endtask

  initial forever begin
    @(posedge clk);
    model_step(reset, fx3_ready, gpi_status, reg_wr_ack);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("usb_connected", usb_connected, m_usb);
      chk("reg_wr_req", reg_wr_req, m_req);
      chk("ack_error", ack_error, err);
      chk("reg_wr_addr", reg_wr_addr, m_addr);
      chk("reg_wr_data", reg_wr_data, m_data);
    end
  end

  // Ack responder: pulses ack ack_delay cycles after req rises (0 = never).
  int unsigned ack_delay = 0;
  int unsigned req_age = 0;
  bit          rand_ack = 0;
  bit          spur_on = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (reg_wr_req) req_age++; else req_age = 0;
    if (rand_ack && reg_wr_req && req_age == 1) ack_delay = $urandom_range(0, 7);
    reg_wr_ack = 1'b0;
    if (reg_wr_req && ack_delay != 0 && req_age == ack_delay) reg_wr_ack = 1'b1;
    else if (!reg_wr_req && spur_on && $urandom_range(0, 7) == 0) reg_wr_ack = 1'b1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fx3_ready = 1'b0;
    gpi_status = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned run_left;
    do_reset();
    chk_en = 1'b1;
    chk("rst_req", reg_wr_req, 8'd0);
    chk("rst_usb", usb_connected, 8'd0);
    chk("rst_data", reg_wr_data, 8'd0);

    // Connect: usb_connected rises at edge 9, link write issues there.
    ack_delay = 2;
    fx3_ready = 1'b1;
    steps(9);
    chk("conn_usb_e8", usb_connected, 8'd0);
    step();
    chk("conn_usb_e9", usb_connected, 8'd1);
    chk("conn_req_e9", reg_wr_req, 8'd1);
    chk("conn_addr", reg_wr_addr, 8'h10);
    chk("conn_data", reg_wr_data, 8'h09);
    steps(2);
    chk("conn_req_acked", reg_wr_req, 8'd0);
    steps(3);

    // Short disconnect glitch while linked.
    fx3_ready = 1'b0;
    steps(2);
    fx3_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("dglitch_usb", usb_connected, 8'd1);
      chk("dglitch_req", reg_wr_req, 8'd0);
    end

    // GPI change while linked.
    gpi_status = 1'b1;
    steps(2);
    chk("gpi_addr", reg_wr_addr, 8'h11);
    chk("gpi_data", reg_wr_data, 8'h13);
    steps(4);

    // Ack on the last permitted cycle.
    ack_delay = 6;
    gpi_status = 1'b0;
    steps(2);
    chk("late_ack_data", reg_wr_data, 8'h21);
    steps(5);
    chk("late_ack_req_held", reg_wr_req, 8'd1);
    step();
    chk("late_ack_req", reg_wr_req, 8'd0);
    chk("late_ack_err", ack_error, 8'd0);
    steps(2);

    // Timeout: no ack.
    ack_delay = 0;
    gpi_status = 1'b1;
    steps(2);
    chk("to_req_rise", reg_wr_req, 8'd1);
    steps(5);
    chk("to_req_held", reg_wr_req, 8'd1);
    step();
    chk("to_req_fall", reg_wr_req, 8'd0);
    chk("to_err", ack_error, 8'd1);
    ack_delay = 2;
    gpi_status = 1'b0;
    steps(2);
    chk("to_next_data", reg_wr_data, 8'h45);
    steps(4);

    // Priority: GPI change and disconnect while a write is outstanding.
    ack_delay = 6;
    gpi_status = 1'b1;
    steps(2);
    chk("prio_req", reg_wr_req, 8'd1);
    fx3_ready = 1'b0;
    gpi_status = 1'b0;
    steps(6);
    chk("prio_req_fall", reg_wr_req, 8'd0);
    step();
    chk("prio_link_req", reg_wr_req, 8'd1);
    chk("prio_link_addr", reg_wr_addr, 8'h10);
    chk("prio_link_data", reg_wr_data, 8'h6C);
    steps(6);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("prio_gpi_dropped", reg_wr_req, 8'd0);
    end
    for (int i = 0; i < 6; i++) begin
      gpi_status = ~gpi_status;
      step();
      chk("disc_gpi_ignored", reg_wr_req, 8'd0);
    end
    gpi_status = 1'b0;
    steps(2);

    // Connect glitch: 5 cycles high.
    fx3_ready = 1'b1;
    steps(5);
    fx3_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cglitch_usb", usb_connected, 8'd0);
      chk("cglitch_req", reg_wr_req, 8'd0);
    end

    // Reset while a request is outstanding, then late/spurious acks.
    do_reset();
    ack_delay = 0;
    fx3_ready = 1'b1;
    steps(10);
    chk("rmw_req", reg_wr_req, 8'd1);
    reset = 1'b1;
    fx3_ready = 1'b0;
    step();
    chk("rmw_req0", reg_wr_req, 8'd0);
    chk("rmw_usb0", usb_connected, 8'd0);
    chk("rmw_addr0", reg_wr_addr, 8'd0);
    chk("rmw_data0", reg_wr_data, 8'd0);
    reset = 1'b0;
    spur_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rmw_no_req", reg_wr_req, 8'd0);
    end
    spur_on = 1'b0;

    // Sequence wrap over 17 acked writes.
    ack_delay = 1;
    fx3_ready = 1'b1;
    steps(12);
    for (int unsigned n = 1; n <= 16; n++) begin
      gpi_status = ~gpi_status;
      steps(2);
      if (n == 15) chk("seq_15", {4'd0, reg_wr_data[7:4]}, 8'd15);
      if (n == 16) chk("seq_wrap", {4'd0, reg_wr_data[7:4]}, 8'd0);
      steps(3);
    end

    // Random traffic.
    rand_ack = 1'b1;
    spur_on = 1'b1;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        fx3_ready = ~fx3_ready;
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      if ($urandom_range(0, 7) == 0) gpi_status = ~gpi_status;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
